// File: rtl/sram_ctrl_pkg.sv
// Shared types and default timing for the SRAM sequencing controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WL    = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int unsigned DEF_ROWS      = 4;
  localparam int unsigned DEF_COLS      = 1;
  localparam int unsigned DEF_SETUP_CYC = 2;
  localparam int unsigned DEF_WL_CYC    = 2;
  localparam int unsigned DEF_HOLD_CYC  = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_seq_ctrl.sv
// Request-driven sequencer for a small SRAM array: precharge/setup, word-line
// pulse, hold, then a completion pulse, all timed by one shared down-counter.
module sram_seq_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned WL_CYC    = DEF_WL_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  localparam int unsigned ADDR_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              rd_wr,
  output logic [COLS-1:0]   data_in,
  output logic [ROWS-1:0]   row,
  input  logic [COLS-1:0]   preout,
  output logic              rsp_valid,
  output logic [COLS-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_MAX = max3(SETUP_CYC, WL_CYC, HOLD_CYC) - 1;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

  if (SETUP_CYC < 1 || WL_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
    $error("sram_seq_ctrl: SETUP_CYC, WL_CYC and HOLD_CYC must each be >= 1");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_ok;

  // Address width can exceed the row count when ROWS is not a power of two.
  assign addr_ok   = ({1'b0, req_addr} < ROWS_L);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      row       <= '0;
      rd_wr     <= 1'b0;
      data_in   <= '0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (addr_ok) begin
              state  <= SETUP;
              cnt    <= CNT_W'(SETUP_CYC - 1);
              we_q   <= req_we;
              addr_q <= req_addr;
              rd_wr  <= ~req_we;
              if (req_we) data_in <= req_wdata;
            end else begin
              rsp_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= WL;
            cnt   <= CNT_W'(WL_CYC - 1);
            row   <= ROWS'(1) << addr_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WL: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= CNT_W'(HOLD_CYC - 1);
            row   <= '0;
            if (!we_q) rsp_rdata <= preout;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            rd_wr     <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Self-checking bench for sram_seq_ctrl: a request-level schedule model plus a
// behavioural cell array driven by the controller's own row/rd_wr/data_in.
module tb_sram_seq_ctrl;

  localparam int ROWS = 5;
  localparam int COLS = 4;
  localparam int S    = 2;
  localparam int W    = 2;
  localparam int H    = 2;
  localparam int TOT  = S + W + H;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rd_wr;
  logic [COLS-1:0] data_in;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] preout;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  sram_seq_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SETUP_CYC(S), .WL_CYC(W), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_wr(rd_wr), .data_in(data_in), .row(row), .preout(preout),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Behavioural cell array: written while a row is high on the write path,
  // read back on the precharge path, noise otherwise.
  logic [COLS-1:0] cells [ROWS];
  logic [COLS-1:0] noise;
  logic            row_any;
  int              row_idx;

  always_comb begin
    row_any = 1'b0;
    row_idx = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (row[i]) begin
        row_any = 1'b1;
        row_idx = i;
      end
    end
    preout = (row_any && rd_wr) ? cells[row_idx] : noise;
  end

  always @(posedge clk) begin
    noise <= COLS'($urandom);
    if (row_any && !rd_wr) cells[row_idx] <= data_in;
  end

  // Request-level model: t counts cycles since the accepting edge.
  int              t = 0;
  logic            cur_we;
  logic [2:0]      cur_addr;
  logic [COLS-1:0] mem_m [ROWS];
  logic            m_rd_wr, m_valid, m_err;
  logic [COLS-1:0] m_data_in, m_rdata;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_rd_wr = 1'b0; m_data_in = '0; m_rdata = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (t == 0) begin
        if (req_valid) begin
          if (int'(req_addr) < ROWS) begin
            t = 1;
            cur_we = req_we;
            cur_addr = req_addr;
            m_rd_wr = !req_we;
            if (req_we) begin
              m_data_in = req_wdata;
              mem_m[req_addr] = req_wdata;
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end else begin
        if (t == S + W && !cur_we) m_rdata = mem_m[cur_addr];
        if (t == TOT) begin
          t = 0;
          m_valid = 1'b1;
          m_rd_wr = 1'b0;
        end else begin
          t++;
        end
      end
    end
  end

  logic [ROWS-1:0] prev_row = '0;
  logic            prev_rd_wr;
  logic [COLS-1:0] prev_data_in;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [ROWS-1:0] m_row;
      m_row = (t >= S + 1 && t <= S + W) ? (ROWS'(1) << cur_addr) : '0;
      check("m_req_ready", 32'(req_ready), 32'(t == 0));
      check("m_row", 32'(row), 32'(m_row));
      check("m_rd_wr", 32'(rd_wr), 32'(m_rd_wr));
      check("m_data_in", 32'(data_in), 32'(m_data_in));
      check("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("m_rsp_err", 32'(rsp_err), 32'(m_err));
      check("m_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      check("row_onehot0", 32'($onehot0(row)), 32'd1);
      if (prev_row != '0 && row != '0) begin
        check("rd_wr_stable_wl", 32'(rd_wr), 32'(prev_rd_wr));
        check("data_in_stable_wl", 32'(data_in), 32'(prev_data_in));
      end
      prev_row = row;
      prev_rd_wr = rd_wr;
      prev_data_in = data_in;
    end
  end

  // Issue one request and pin the fixed 7-cycle schedule with literal values.
  task automatic op_lit(input logic we, input logic [2:0] addr, input logic [COLS-1:0] wd,
                        input logic [COLS-1:0] rd_exp);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      check("lit_row", 32'(row), (c == 3 || c == 4) ? 32'(1) << addr : 32'd0);
      check("lit_rd_wr", 32'(rd_wr), (c <= 6) ? 32'(!we) : 32'd0);
      check("lit_valid", 32'(rsp_valid), 32'(c == 7));
      check("lit_ready", 32'(req_ready), 32'(c == 7));
      if (we && c == 3) check("lit_data_in", 32'(data_in), 32'(wd));
      if (!we && c == 7) check("lit_rdata", 32'(rsp_rdata), 32'(rd_exp));
    end
  endtask

  initial begin
    for (int i = 0; i < ROWS; i++) begin
      cells[i] = '0;
      mem_m[i] = '0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_row", 32'(row), 32'd0);
    check("rst_rd_wr", 32'(rd_wr), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_valid", 32'(rsp_valid | rsp_err), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    op_lit(1'b1, 3'd0, 4'h1, 4'h0);
    check("wr0_row_onehot", 32'(data_in), 32'h1);
    op_lit(1'b0, 3'd0, 4'h0, 4'h1);
    op_lit(1'b1, 3'd0, 4'h0, 4'h0);
    op_lit(1'b0, 3'd0, 4'h0, 4'h0);
    op_lit(1'b1, 3'd2, 4'hA, 4'h0);

    // Two reads with req_valid held: second accepted in the completion cycle.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
    @(negedge clk);
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 8) req_valid = 1'b0;
      check("b2b_ready", 32'(req_ready), 32'(c == 7 || c == 14));
      check("b2b_valid", 32'(rsp_valid), 32'(c == 7 || c == 14));
      if (c == 7 || c == 14) check("b2b_rdata", 32'(rsp_rdata), 32'hA);
    end

    // Out-of-range row: error pulse only, nothing else moves.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      check("bad_err", 32'(rsp_err), 32'(c == 1));
      check("bad_row", 32'(row), 32'd0);
      check("bad_valid", 32'(rsp_valid), 32'd0);
      check("bad_data_in", 32'(data_in), 32'hA);
      check("bad_ready", 32'(req_ready), 32'd1);
    end

    // Reset during the first word-line cycle of a read.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wl_row_before_rst", 32'(row), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    check("wlrst_row", 32'(row), 32'd0);
    check("wlrst_rd_wr", 32'(rd_wr), 32'd0);
    check("wlrst_data_in", 32'(data_in), 32'd0);
    check("wlrst_rdata", 32'(rsp_rdata), 32'd0);
    check("wlrst_pulses", 32'(rsp_valid | rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("wlrst_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("wlrst_no_valid", 32'(rsp_valid), 32'd0);
    end

    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 3'($urandom_range(0, 7));
      req_wdata = COLS'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
